debounce_pulse_gen: RTL and testbench

- Upstream conditioning stage for the sticky-set D flip-flop flag register.
- Takes a raw, asynchronous, possibly bouncing input (button or external event line).
- Synchronises and debounces it, then emits single-cycle rise/fall pulses plus a clean debounced level.
- `rise_pulse` drives the flag register's d input, so one clean event sets the flag exactly once.

---
 rtl/debounce_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_debounce_pulse_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse_gen.sv
// debounce_pulse_gen: synchronises and debounces a raw asynchronous input,
// then produces a clean level plus single-cycle rise/fall event pulses.
//
// Ports:
//   clk        - rising-edge clock, single domain
//   rst        - synchronous active-high reset
//   din        - raw asynchronous (possibly bouncing) input
//   en         - debounce enable; 0 freezes acceptance of new levels
//   level_out  - debounced level (registered)
//   rise_pulse - one-cycle pulse on an accepted 0->1 transition
//   fall_pulse - one-cycle pulse on an accepted 1->0 transition
//   busy       - high while a candidate transition is being qualified
//
// Parameters:
//   DEBOUNCE_CYCLES - sampled cycles a new value must hold (2 .. 2**CNT_W-1)
//   CNT_W           - width of the stability counter
module debounce_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } state_t;

    // Count value reached on the last qualifying sample before acceptance.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             s1;
    logic             s2;
    logic             level_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             busy_nxt;

    // Synchroniser runs regardless of en; only s2 is seen by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOW;
            cnt        <= CNT_ZERO;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            level_out  <= level_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            LOW: begin
                if (s2 && en) begin
                    // The entering sample already counts as the first one.
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = CNT_ZERO;
                end
            end

            WAIT_HIGH: begin
                if (!en || !s2) begin
                    state_nxt = LOW;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_ZERO;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            HIGH: begin
                if (!s2 && en) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = CNT_ZERO;
                end
            end

            WAIT_LOW: begin
                if (!en || s2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = CNT_ZERO;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = LOW;
                cnt_nxt   = CNT_ZERO;
                level_nxt = 1'b0;
            end
        endcase

        // busy is registered alongside the state it describes.
        busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
    end

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// tb_debounce_pulse_gen: table-driven directed vectors, hand-written corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_debounce_pulse_gen;

    localparam int D = 4;

    logic clk;
    logic rst;
    logic din;
    logic en;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks;
    int passed;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       din;
        logic [3:0] exp;  // {level, rise, fall, busy}
    } vec_t;

    vec_t vecs[$];

    // Reference model state: accepted level, length of the current run of
    // enabled samples disagreeing with it, and recent raw din samples.
    int   m_level;
    int   m_run;
    logic m_rise;
    logic m_fall;
    logic m_busy;
    logic hist[$];

    debounce_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .en(en),
        .level_out(level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] dut_vec();
        return {level_out, rise_pulse, fall_pulse, busy};
    endfunction

    function automatic logic [3:0] model_vec();
        return {m_level[0], m_rise, m_fall, m_busy};
    endfunction

    function automatic void add(input logic r, input logic e,
                                input logic d, input logic [3:0] x);
        vec_t v;
        v.rst = r;
        v.en  = e;
        v.din = d;
        v.exp = x;
        vecs.push_back(v);
    endfunction

    // The FSM at this edge sees the din sampled two edges earlier.
    function automatic void model_step(input logic r, input logic e,
                                       input logic d);
        logic seen;
        if (r) begin
            hist.delete();
            m_level = 0;
            m_run   = 0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_busy  = 1'b0;
            return;
        end
        seen = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (e && (int'(seen) != m_level)) m_run = m_run + 1;
        else m_run = 0;
        if (m_run == D) begin
            m_level = 1 - m_level;
            m_rise  = (m_level == 1);
            m_fall  = (m_level == 0);
            m_run   = 0;
        end
        m_busy = (m_run != 0);
    endfunction

    task automatic check(input string name, input logic [3:0] got,
                         input logic [3:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got {lvl,rise,fall,busy}=%b expected %b at %0t",
                     name, got, exp, $time);
        else
            passed++;
    endtask

    task automatic step(input logic r, input logic e, input logic d);
        rst = r;
        en  = e;
        din = d;
        @(posedge clk);
        model_step(r, e, d);
        #1;
    endtask

    initial begin
        logic       r;
        logic       e;
        logic       d;
        int         hold;
        logic [3:0] x;

        checks = 0;
        passed = 0;
        rst = 1'b1;
        en  = 1'b1;
        din = 1'b1;
        model_step(1'b1, 1'b1, 1'b1);

        // Reset held with din high.
        repeat (3) add(1, 1, 1, 4'b0000);
        // Clean rise.
        add(0, 1, 1, 4'b0000);
        add(0, 1, 1, 4'b0000);
        add(0, 1, 1, 4'b0001);
        add(0, 1, 1, 4'b0001);
        add(0, 1, 1, 4'b0001);
        add(0, 1, 1, 4'b1100);
        add(0, 1, 1, 4'b1000);
        add(0, 1, 1, 4'b1000);
        // Clean fall, din low for 6 edges then held.
        add(0, 1, 0, 4'b1000);
        add(0, 1, 0, 4'b1000);
        add(0, 1, 0, 4'b1001);
        add(0, 1, 0, 4'b1001);
        add(0, 1, 0, 4'b1001);
        add(0, 1, 0, 4'b0010);
        add(0, 1, 0, 4'b0000);
        add(0, 1, 0, 4'b0000);
        // Bounce: high 2, low 1, high 2, then low.
        add(0, 1, 1, 4'b0000);
        add(0, 1, 1, 4'b0000);
        add(0, 1, 0, 4'b0001);
        add(0, 1, 1, 4'b0001);
        add(0, 1, 1, 4'b0000);
        add(0, 1, 0, 4'b0001);
        add(0, 1, 0, 4'b0001);
        add(0, 1, 0, 4'b0000);
        add(0, 1, 0, 4'b0000);
        add(0, 1, 0, 4'b0000);
        // Enable gating: toggles then held high with en low.
        add(0, 0, 1, 4'b0000);
        add(0, 0, 0, 4'b0000);
        add(0, 0, 1, 4'b0000);
        add(0, 0, 0, 4'b0000);
        repeat (10) add(0, 0, 1, 4'b0000);
        // Re-enable with s2 already high.
        add(0, 1, 1, 4'b0001);
        add(0, 1, 1, 4'b0001);
        add(0, 1, 1, 4'b0001);
        add(0, 1, 1, 4'b1100);
        add(0, 1, 1, 4'b1000);
        // Disabled while high, din drops: level holds.
        repeat (6) add(0, 0, 0, 4'b1000);
        add(0, 1, 0, 4'b1001);
        add(0, 1, 0, 4'b1001);
        add(0, 1, 0, 4'b1001);
        add(0, 1, 0, 4'b0010);
        add(0, 1, 0, 4'b0000);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].din);
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Reset during WAIT_HIGH discards the candidate.
        step(1, 1, 0);
        step(1, 1, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, 1);
        check("midrst_busy", dut_vec(), 4'b0001);
        step(1, 1, 1);
        check("midrst_rst", dut_vec(), 4'b0000);
        for (int i = 1; i <= D + 2; i++) begin
            step(0, 1, 1);
            if (i < 3) x = 4'b0000;
            else if (i < D + 2) x = 4'b0001;
            else x = 4'b1100;
            check($sformatf("midrst_after%0d", i), dut_vec(), x);
        end
        step(0, 1, 1);
        check("midrst_settle", dut_vec(), 4'b1000);

        // Randomized bouncing input against the model.
        d = 1'b0;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                d    = ~d;
                hold = $urandom_range(1, 7);
            end
            hold--;
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 199) == 0);
            step(r, e, d);
            check($sformatf("rand%0d", c), dut_vec(), model_vec());
            if (rise_pulse && fall_pulse) begin
                checks++;
                $display("FAIL rand_excl%0d: rise=%b fall=%b both high, required not both",
                         c, rise_pulse, fall_pulse);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
